// File: rtl/adc_capture_if.sv
// ADC SPI pins, capture-RAM write port and control inputs of the capture engine.
`timescale 1ns/1ps
interface adc_capture_if;
  logic        adc_convst;
  logic        adc_sck;
  logic        adc_sdi;
  logic        adc_sdo;
  logic [11:0] adc_ram_addr;
  logic [31:0] adc_ram_rd_data;
  logic        adc_ram_we;
  logic [31:0] adc_ram_wr_data;
  logic [31:0] adc_config_odd;
  logic [31:0] adc_config_even;
  logic        adc_start;
  logic        adc_sequence_one;

  modport master (
    output adc_convst, adc_sck, adc_sdi, adc_ram_addr, adc_ram_we, adc_ram_wr_data,
    input  adc_sdo, adc_ram_rd_data, adc_config_odd, adc_config_even,
    input  adc_start, adc_sequence_one
  );

  modport slave (
    input  adc_convst, adc_sck, adc_sdi, adc_ram_addr, adc_ram_we, adc_ram_wr_data,
    output adc_sdo, adc_ram_rd_data, adc_config_odd, adc_config_even,
    output adc_start, adc_sequence_one
  );
endinterface

// File: rtl/adc_capture.sv
// Free-running LTC2308 capture: per frame pulse CONVST, wait, shift 12 bits in / 6 config bits out,
// then write {cfg_prev, sample} to the capture RAM. All outputs are registers decoded from the next frame count.
`timescale 1ns/1ps
module adc_capture #(
  parameter int FRAME_CYCLES  = 320,
  parameter int CONVST_CYCLES = 4,
  parameter int CONV_WAIT     = 256,
  parameter int SCK_HALF      = 2,
  parameter int LAST_ADDR     = 4095
) (
  input logic         clk,
  input logic         reset,
  adc_capture_if.master bus
);

  localparam int CW = $clog2(FRAME_CYCLES);
  localparam int SCK_START = CONVST_CYCLES + CONV_WAIT;
  localparam int WR_CYC = SCK_START + 12 * 2 * SCK_HALF;

  localparam logic [CW-1:0] P_LAST   = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] P_CONVST = CW'(CONVST_CYCLES);
  localparam logic [CW-1:0] P_START  = CW'(SCK_START);
  localparam logic [CW-1:0] P_WR     = CW'(WR_CYC);
  localparam logic [CW-1:0] P_BIT    = CW'(2 * SCK_HALF);
  localparam logic [CW-1:0] P_HALF   = CW'(SCK_HALF);
  localparam logic [11:0]   ADDR_LAST = 12'(LAST_ADDR);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] c;
  logic          frame_odd;
  logic [5:0]    cfg;
  logic [5:0]    cfg_prev;
  logic [11:0]   sample;
  logic          stop;

  logic [CW-1:0] nc;
  logic [CW-1:0] rel;
  logic [CW-1:0] bit_k;
  logic [CW-1:0] phase;
  logic          in_xfer;
  logic          sck_hi;
  logic          smp_edge;
  logic          sdi_bit;
  logic          last_write;

  logic unused_ok;
  assign unused_ok = ^{bus.adc_ram_rd_data, bus.adc_config_odd[31:6], bus.adc_config_even[31:6]};

  // Outputs are decoded from the count of the coming cycle so they register in step with c.
  always_comb begin
    nc       = (c == P_LAST) ? '0 : c + 1'b1;
    rel      = nc - P_START;
    bit_k    = rel / P_BIT;
    phase    = rel % P_BIT;
    in_xfer  = (nc >= P_START) && (nc < P_WR);
    sck_hi   = in_xfer && (phase >= P_HALF);
    smp_edge = in_xfer && (phase == P_HALF);
    sdi_bit  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (in_xfer && bit_k == CW'(i)) sdi_bit = cfg[5-i];
    end
    last_write = bus.adc_sequence_one && (bus.adc_ram_addr == ADDR_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= S_IDLE;
      c                   <= '0;
      frame_odd           <= 1'b0;
      cfg                 <= '0;
      cfg_prev            <= '0;
      sample              <= '0;
      stop                <= 1'b0;
      bus.adc_convst      <= 1'b0;
      bus.adc_sck         <= 1'b0;
      bus.adc_sdi         <= 1'b0;
      bus.adc_ram_we      <= 1'b0;
      bus.adc_ram_addr    <= '0;
      bus.adc_ram_wr_data <= '0;
    end else if (bus.adc_start) begin
      state            <= S_ARMED;
      c                <= '0;
      frame_odd        <= 1'b0;
      cfg_prev         <= '0;
      stop             <= 1'b0;
      bus.adc_convst   <= 1'b0;
      bus.adc_sck      <= 1'b0;
      bus.adc_sdi      <= 1'b0;
      bus.adc_ram_we   <= 1'b0;
      bus.adc_ram_addr <= '0;
    end else begin
      case (state)
        S_ARMED: begin
          state          <= S_RUN;
          c              <= '0;
          frame_odd      <= 1'b0;
          cfg            <= bus.adc_config_even[5:0];
          cfg_prev       <= '0;
          stop           <= 1'b0;
          bus.adc_convst <= 1'b1;
        end
        S_RUN: begin
          c              <= nc;
          bus.adc_convst <= (nc < P_CONVST);
          bus.adc_sck    <= sck_hi;
          bus.adc_sdi    <= sdi_bit;
          bus.adc_ram_we <= (nc == P_WR);
          if (nc == P_WR) bus.adc_ram_wr_data <= {14'b0, cfg_prev, sample};
          if (smp_edge) sample <= {sample[10:0], bus.adc_sdo};
          // The write cycle itself decides whether this frame is the last of a single fill.
          if (c == P_WR) begin
            stop <= last_write;
            if (!last_write)
              bus.adc_ram_addr <= (bus.adc_ram_addr == ADDR_LAST) ? 12'd0 : bus.adc_ram_addr + 12'd1;
          end
          if (c == P_LAST) begin
            if (stop) begin
              state          <= S_DONE;
              c              <= '0;
              bus.adc_convst <= 1'b0;
            end else begin
              frame_odd <= ~frame_odd;
              cfg       <= frame_odd ? bus.adc_config_even[5:0] : bus.adc_config_odd[5:0];
              cfg_prev  <= cfg;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture: PRBS-driven SDO, scoreboard of expected RAM writes, timing monitors.
`timescale 1ns/1ps
module tb_adc_capture;
  localparam int LAST = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #3.125 clk = ~clk;

  adc_capture_if bus();
  adc_capture #(.LAST_ADDR(LAST)) dut (.clk(clk), .reset(reset), .bus(bus.master));

  int n_assert = 0;
  int n_fail   = 0;

  logic [30:0] lfsr = 31'h34013FF7;
  assign bus.adc_sdo = lfsr[30];
  assign bus.adc_ram_rd_data = 32'hDEADBEEF;

  logic [43:0] sb[$];
  int          nbits = 0;
  logic [11:0] rx = '0;
  int          m_addr = 0;
  int          m_frame = 0;
  logic [5:0]  m_cfg_prev = '0;
  logic [5:0]  cfg_even6 = 6'b010101;
  logic [5:0]  cfg_odd6  = 6'b101010;

  int cyc = 0, t_rise = 0, t_fall = 0, t_srise = 0;
  int sck_cnt = 0, n_writes = 0, n_convst = 0;
  bit contig = 0;
  logic p_convst = 0, p_sck = 0, p_we = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_restart();
    sb.delete();
    nbits = 0;
    m_addr = 0;
    m_frame = 0;
    m_cfg_prev = '0;
    sck_cnt = 0;
    contig = 0;
  endtask

  task automatic wait_writes(input int target, input int budget);
    int n = 0;
    while (n_writes < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("write_budget", 64'(n_writes >= target), 64'd1);
  endtask

  // ADC model: bit present at each SCK rise becomes the expected sample; SDI checked against cfg.
  always @(posedge bus.adc_sck) begin
    automatic logic [5:0] cc = m_frame[0] ? cfg_odd6 : cfg_even6;
    if (nbits < 6) check("sdi_bit", 64'(bus.adc_sdi), 64'(cc[5-nbits]));
    rx = {rx[10:0], lfsr[30]};
    nbits++;
    if (nbits == 12) begin
      sb.push_back({12'(m_addr), 14'b0, m_cfg_prev, rx});
      m_cfg_prev = cc;
      m_frame++;
      if (!(bus.adc_sequence_one && m_addr == LAST)) m_addr = (m_addr == LAST) ? 0 : m_addr + 1;
      nbits = 0;
    end
    lfsr = {lfsr[29:0], lfsr[30] ^ lfsr[27]};
  end

  always @(negedge clk) begin
    cyc++;
    if (bus.adc_convst && !p_convst) begin
      if (contig) check("frame_period", 64'(cyc - t_rise), 64'd320);
      t_rise = cyc;
      n_convst++;
    end
    if (!bus.adc_convst && p_convst) begin
      check("convst_width", 64'(cyc - t_rise), 64'd4);
      t_fall = cyc;
    end
    if (bus.adc_sck && !p_sck) begin
      if (sck_cnt == 0) check("sck_first_wait", 64'((cyc - t_fall) >= 256), 64'd1);
      else check("sck_period", 64'(cyc - t_srise), 64'd4);
      t_srise = cyc;
      sck_cnt++;
    end
    if (bus.adc_ram_we) begin
      n_writes++;
      check("we_single", 64'(p_we), 64'd0);
      check("we_offset", 64'(cyc - t_rise), 64'd308);
      check("sck_pulses", 64'(sck_cnt), 64'd12);
      sck_cnt = 0;
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        automatic logic [43:0] e = sb.pop_front();
        check("wr_addr", 64'(bus.adc_ram_addr), 64'(e[43:32]));
        check("wr_data", 64'(bus.adc_ram_wr_data), 64'(e[31:0]));
      end
      contig = 1;
    end
    p_convst = bus.adc_convst;
    p_sck    = bus.adc_sck;
    p_we     = bus.adc_ram_we;
  end

  initial begin
    int n;
    int wr_before;
    int cv_before;
    bus.adc_start        = 1'b1;
    bus.adc_sequence_one = 1'b0;
    bus.adc_config_even  = {26'h3FFFFFF, cfg_even6};
    bus.adc_config_odd   = {26'h1555555, cfg_odd6};
    repeat (5) @(negedge clk);
    check("rst_convst", 64'(bus.adc_convst), 64'd0);
    check("rst_sck", 64'(bus.adc_sck), 64'd0);
    check("rst_sdi", 64'(bus.adc_sdi), 64'd0);
    check("rst_we", 64'(bus.adc_ram_we), 64'd0);
    check("rst_addr", 64'(bus.adc_ram_addr), 64'd0);
    check("rst_wr_data", 64'(bus.adc_ram_wr_data), 64'd0);

    reset = 1'b0;
    repeat (13) @(negedge clk);
    check("armed_idle", 64'({bus.adc_convst, bus.adc_sck, bus.adc_sdi, bus.adc_ram_we}), 64'd0);
    check("armed_addr", 64'(bus.adc_ram_addr), 64'd0);
    model_restart();
    bus.adc_start = 1'b0;

    // Continuous mode: frames 0..2 then through the address wrap.
    wait_writes(3, 3 * 320 + 20);
    wait_writes(LAST + 3, (LAST + 1) * 320 + 20);

    // Abort during the transfer at c=280.
    n = 0;
    while (!bus.adc_convst && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("convst_found", 64'(bus.adc_convst), 64'd1);
    repeat (280) @(negedge clk);
    bus.adc_start = 1'b1;
    model_restart();
    @(negedge clk);
    check("abort_sck", 64'(bus.adc_sck), 64'd0);
    check("abort_we", 64'(bus.adc_ram_we), 64'd0);
    check("abort_addr", 64'(bus.adc_ram_addr), 64'd0);
    check("abort_convst", 64'(bus.adc_convst), 64'd0);
    repeat (2) @(negedge clk);

    // Single fill: LAST+1 writes then DONE.
    bus.adc_sequence_one = 1'b1;
    wr_before = n_writes;
    bus.adc_start = 1'b0;
    wait_writes(wr_before + LAST + 1, (LAST + 2) * 320);
    repeat (700) @(negedge clk);
    wr_before = n_writes;
    cv_before = n_convst;
    repeat (700) @(negedge clk);
    check("done_no_we", 64'(n_writes), 64'(wr_before));
    check("done_no_convst", 64'(n_convst), 64'(cv_before));
    check("done_addr", 64'(bus.adc_ram_addr), 64'(LAST));
    check("done_sb_empty", 64'(sb.size()), 64'd0);

    // Restart from DONE.
    bus.adc_start = 1'b1;
    model_restart();
    repeat (2) @(negedge clk);
    bus.adc_start = 1'b0;
    wr_before = n_writes;
    wait_writes(wr_before + 2, 3 * 320);
    check("end_sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
